// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall logic: register index width,
// stall FSM encoding and default sizing of the memory-wait watchdog.
package hazard_stall_unit_pkg;

   localparam int REG_W        = 4;
   localparam int WAIT_MAX_DEF = 64;
   localparam int CNT_W_DEF    = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID/EXE/MEM pipeline view seen by the stall unit plus its stall controls.
// The pipeline side is the master; the stall unit is the slave.
interface hazard_stall_unit_if;
   import hazard_stall_unit_pkg::*;

   logic [REG_W-1:0] src1;
   logic [REG_W-1:0] src2;
   logic             two_src;
   logic             fwd_en;
   logic [REG_W-1:0] EXE_Dest;
   logic             EXE_WB_EN;
   logic             EXE_MEM_R_EN;
   logic [REG_W-1:0] MEM_Dest;
   logic             MEM_WB_EN;
   logic             MEM_R_EN;
   logic             MEM_W_EN;
   logic             mem_ready;
   logic             hazard;
   logic             freeze;
   logic             timeout;

   modport master (
      output src1, src2, two_src, fwd_en,
      output EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
      output MEM_Dest, MEM_WB_EN, MEM_R_EN, MEM_W_EN, mem_ready,
      input  hazard, freeze, timeout
   );

   modport slave (
      input  src1, src2, two_src, fwd_en,
      input  EXE_Dest, EXE_WB_EN, EXE_MEM_R_EN,
      input  MEM_Dest, MEM_WB_EN, MEM_R_EN, MEM_W_EN, mem_ready,
      output hazard, freeze, timeout
   );

endinterface

// File: rtl/hazard_stall_unit_hazard_match.sv
// RAW dependency compare of ID sources against EXE/MEM destinations; purely combinational.
// No flow control: the result is a level that holds IF/ID while the dependency persists.
module hazard_match
   import hazard_stall_unit_pkg::*;
(
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic             fwd_en,
   input  logic [REG_W-1:0] EXE_Dest,
   input  logic             EXE_WB_EN,
   input  logic             EXE_MEM_R_EN,
   input  logic [REG_W-1:0] MEM_Dest,
   input  logic             MEM_WB_EN,
   output logic             hazard
);

   logic m_exe1, m_exe2, m_mem1, m_mem2;

   assign m_exe1 = EXE_WB_EN & (src1 == EXE_Dest);
   assign m_exe2 = EXE_WB_EN & two_src & (src2 == EXE_Dest);
   assign m_mem1 = MEM_WB_EN & (src1 == MEM_Dest);
   assign m_mem2 = MEM_WB_EN & two_src & (src2 == MEM_Dest);

   // With forwarding only a load in EXE cannot be bypassed; one bubble moves it into MEM.
   always_comb begin
      hazard = 1'b0;
      if (fwd_en)
         hazard = EXE_MEM_R_EN & (m_exe1 | m_exe2);
      else
         hazard = m_exe1 | m_exe2 | m_mem1 | m_mem2;
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall control: combinational hazard/freeze, registered sticky timeout; optional
// HAZARD_STALL_PERF_EN adds a saturating stall-cycle counter. freeze holds every stage while SRAM is busy.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   hazard_stall_unit_if.slave  bus
`ifdef HAZARD_STALL_PERF_EN
   ,
   output logic [CNT_W-1:0]    stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             timeout_q, timeout_set;
   logic             freeze_c;
   logic             mem_req;

   hazard_match u_hazard_match (
      .src1         (bus.src1),
      .src2         (bus.src2),
      .two_src      (bus.two_src),
      .fwd_en       (bus.fwd_en),
      .EXE_Dest     (bus.EXE_Dest),
      .EXE_WB_EN    (bus.EXE_WB_EN),
      .EXE_MEM_R_EN (bus.EXE_MEM_R_EN),
      .MEM_Dest     (bus.MEM_Dest),
      .MEM_WB_EN    (bus.MEM_WB_EN),
      .hazard       (bus.hazard)
   );

   assign mem_req = bus.MEM_R_EN | bus.MEM_W_EN;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_set)
            timeout_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_req && !bus.mem_ready) begin
               state_nxt    = ST_WAIT;
               wait_cnt_nxt = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (bus.mem_ready) begin
               state_nxt    = ST_IDLE;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               // Access abandoned: release the pipeline and leave the sticky flag behind.
               state_nxt    = ST_IDLE;
               wait_cnt_nxt = '0;
               timeout_set  = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      freeze_c = 1'b0;
      case (state)
         ST_IDLE: freeze_c = mem_req & ~bus.mem_ready;
         ST_WAIT: freeze_c = ~bus.mem_ready & (wait_cnt != WAIT_LAST);
         default: freeze_c = 1'b0;
      endcase
   end

   assign bus.freeze  = freeze_c;
   assign bus.timeout = timeout_q;

`ifdef HAZARD_STALL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= '0;
      else if ((bus.hazard | freeze_c) && (stall_cycles != '1))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: dut_a uses default sizing, dut_b a tiny watchdog (WAIT_MAX=4, CNT_W=2).
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_stall_unit_if if_a ();
   hazard_stall_unit_if if_b ();

`ifdef HAZARD_STALL_PERF_EN
   logic [15:0] stall_a;
   logic [1:0]  stall_b;
`endif

   hazard_stall_unit #(.WAIT_MAX(64), .CNT_W(16)) dut_a (
      .clk (clk), .rst (rst_a), .bus (if_a.slave)
`ifdef HAZARD_STALL_PERF_EN
      , .stall_cycles (stall_a)
`endif
   );

   hazard_stall_unit #(.WAIT_MAX(4), .CNT_W(2)) dut_b (
      .clk (clk), .rst (rst_b), .bus (if_b.slave)
`ifdef HAZARD_STALL_PERF_EN
      , .stall_cycles (stall_b)
`endif
   );

   typedef struct packed {
      logic h;
      logic f;
      logic t;
      logic st;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      if_a.src1 = 0; if_a.src2 = 0; if_a.two_src = 0; if_a.fwd_en = 1;
      if_a.EXE_Dest = 0; if_a.EXE_WB_EN = 0; if_a.EXE_MEM_R_EN = 0;
      if_a.MEM_Dest = 0; if_a.MEM_WB_EN = 0; if_a.MEM_R_EN = 0; if_a.MEM_W_EN = 0;
      if_a.mem_ready = 0;
      if_b.src1 = 0; if_b.src2 = 0; if_b.two_src = 0; if_b.fwd_en = 1;
      if_b.EXE_Dest = 0; if_b.EXE_WB_EN = 0; if_b.EXE_MEM_R_EN = 0;
      if_b.MEM_Dest = 0; if_b.MEM_WB_EN = 0; if_b.MEM_R_EN = 0; if_b.MEM_W_EN = 0;
      if_b.mem_ready = 0;
   endtask

   // Push the expectation for the cycle just driven, compare before the edge, then advance.
   task automatic step(input bit sel, input string tag, input logic h, input logic f,
                       input logic t, input logic st);
      exp_t e;
      sb_q.push_back('{h: h, f: f, t: t, st: st});
      @(negedge clk);
      e = sb_q.pop_front();
      if (sel) begin
         check({tag, ".hazard"},  16'(if_b.hazard),  16'(e.h));
         check({tag, ".freeze"},  16'(if_b.freeze),  16'(e.f));
         check({tag, ".timeout"}, 16'(if_b.timeout), 16'(e.t));
         check({tag, ".state"},   16'(dut_b.state),  16'(e.st));
      end else begin
         check({tag, ".hazard"},  16'(if_a.hazard),  16'(e.h));
         check({tag, ".freeze"},  16'(if_a.freeze),  16'(e.f));
         check({tag, ".timeout"}, 16'(if_a.timeout), 16'(e.t));
         check({tag, ".state"},   16'(dut_a.state),  16'(e.st));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      step(0, "reset_a", 0, 0, 0, ST_IDLE);
      step(1, "reset_b", 0, 0, 0, ST_IDLE);
`ifdef HAZARD_STALL_PERF_EN
      check("reset_stall_b", 16'(stall_b), 16'd0);
`endif

      // Load-use with forwarding: one bubble, then the load sits in MEM and is forwarded.
      if_a.fwd_en = 1; if_a.EXE_MEM_R_EN = 1; if_a.EXE_WB_EN = 1; if_a.EXE_Dest = 3; if_a.src1 = 3;
      step(0, "load_use", 1, 0, 0, ST_IDLE);
      if_a.EXE_MEM_R_EN = 0; if_a.EXE_WB_EN = 0;
      if_a.MEM_Dest = 3; if_a.MEM_WB_EN = 1; if_a.MEM_R_EN = 1; if_a.mem_ready = 1;
      step(0, "load_in_mem", 0, 0, 0, ST_IDLE);
      idle_inputs();
      if_a.EXE_MEM_R_EN = 1; if_a.EXE_WB_EN = 1; if_a.EXE_Dest = 3;
      if_a.src1 = 4; if_a.two_src = 0; if_a.src2 = 3;
      step(0, "src2_ignored", 0, 0, 0, ST_IDLE);
      if_a.two_src = 1;
      step(0, "src2_used", 1, 0, 0, ST_IDLE);

      // No forwarding: MEM and plain EXE dependencies stall too.
      idle_inputs();
      if_a.fwd_en = 0; if_a.MEM_WB_EN = 1; if_a.MEM_Dest = 7; if_a.src2 = 7; if_a.two_src = 1;
      step(0, "nofwd_mem", 1, 0, 0, ST_IDLE);
      if_a.fwd_en = 1;
      step(0, "fwd_mem", 0, 0, 0, ST_IDLE);
      idle_inputs();
      if_a.fwd_en = 0; if_a.EXE_WB_EN = 1; if_a.EXE_Dest = 15; if_a.src1 = 15;
      step(0, "nofwd_exe_r15", 1, 0, 0, ST_IDLE);

      // Memory wait: five busy cycles, then ready releases the freeze in the same cycle.
      idle_inputs();
      if_a.MEM_R_EN = 1;
      step(0, "wait_c1", 0, 1, 0, ST_IDLE);
      for (int i = 2; i <= 5; i++) step(0, $sformatf("wait_c%0d", i), 0, 1, 0, ST_WAIT);
      if_a.mem_ready = 1;
      step(0, "wait_ready", 0, 0, 0, ST_WAIT);
      idle_inputs();
      step(0, "wait_done", 0, 0, 0, ST_IDLE);

      // Zero-wait store never freezes.
      if_a.MEM_W_EN = 1; if_a.mem_ready = 1;
      step(0, "zw_store", 0, 0, 0, ST_IDLE);
      step(0, "zw_store2", 0, 0, 0, ST_IDLE);
      idle_inputs();

      // Watchdog on dut_b: three frozen cycles, released on the fourth, sticky flag afterwards.
      if_b.MEM_R_EN = 1;
      step(1, "wd_c1", 0, 1, 0, ST_IDLE);
      step(1, "wd_c2", 0, 1, 0, ST_WAIT);
      step(1, "wd_c3", 0, 1, 0, ST_WAIT);
      step(1, "wd_c4", 0, 0, 0, ST_WAIT);
      if_b.MEM_R_EN = 0;
      step(1, "wd_sticky1", 0, 0, 1, ST_IDLE);
      if_b.MEM_W_EN = 1; if_b.mem_ready = 1;
      step(1, "wd_sticky2", 0, 0, 1, ST_IDLE);
      idle_inputs();
      rst_b = 1'b1;
      step(1, "wd_rst_cycle", 0, 0, 1, ST_IDLE);
      rst_b = 1'b0;
      step(1, "wd_after_rst", 0, 0, 0, ST_IDLE);

`ifdef HAZARD_STALL_PERF_EN
      // Saturating stall counter: 1,2,3,3,3 after successive stall edges.
      if_b.fwd_en = 0; if_b.EXE_WB_EN = 1; if_b.EXE_Dest = 2; if_b.src1 = 2;
      for (int k = 1; k <= 5; k++) begin
         step(1, $sformatf("perf_c%0d", k), 1, 0, 0, ST_IDLE);
         check($sformatf("perf_cnt%0d", k), 16'(stall_b), 16'((k > 3) ? 3 : k));
      end
      idle_inputs();
      if_b.MEM_R_EN = 1;
      step(1, "perf_w1", 0, 1, 0, ST_IDLE);
      step(1, "perf_w2", 0, 1, 0, ST_WAIT);
      if_b.MEM_R_EN = 0;
      rst_b = 1'b1;
      step(1, "perf_rst", 0, 1, 0, ST_WAIT);
      rst_b = 1'b0;
      check("perf_cnt_rst", 16'(stall_b), 16'd0);
      step(1, "perf_after_rst", 0, 0, 0, ST_IDLE);
      check("perf_cnt_idle", 16'(stall_b), 16'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side partner of the operand forwarding logic in the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB). Forwarding cannot resolve every dependency, so this block decides when the pipeline must stop instead.
- Detects RAW hazards that forwarding cannot cover: load-use always; all EXE/MEM dependencies when forwarding is disabled.
- Runs a memory-wait FSM that freezes the whole pipeline while the SRAM access in MEM is outstanding, with a timeout watchdog.
- Sits beside the ID stage; drives the IF/ID hold, the ID/EXE bubble insert and the global freeze.

Parameters:
- WAIT_MAX, 64, maximum WAIT cycles before timeout; valid range 2..65535.
- CNT_W, 16, width of the wait counter and the optional stall counter.

Ports:
- clk  in  1  pipeline clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- src1  in  4  ID-stage Rn.
- src2  in  4  ID-stage Rm/Rd-for-store.
- two_src  in  1  ID instruction reads src2.
- fwd_en  in  1  forwarding enabled.
- EXE_Dest  in  4  destination register in EXE.
- EXE_WB_EN  in  1  EXE instruction writes back.
- EXE_MEM_R_EN  in  1  EXE instruction is a load.
- MEM_Dest  in  4  destination register in MEM.
- MEM_WB_EN  in  1  MEM instruction writes back.
- MEM_R_EN  in  1  MEM load.
- MEM_W_EN  in  1  MEM store.
- mem_ready  in  1  SRAM controller: access complete this cycle.
- hazard  out  1  hold PC and IF/ID; insert bubble into ID/EXE.
- freeze  out  1  hold every pipeline register.
- timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  only present with the optional feature.

Behaviour:
- Reset (sync, rst=1 at rising clk): state=IDLE, wait_cnt=0, timeout=0, stall_cycles=0. Reset mid-WAIT aborts the wait immediately. hazard and freeze are combinational and read 0 whenever their inputs are idle.
- Match terms: m_exe1 = EXE_WB_EN & (src1==EXE_Dest); m_exe2 = EXE_WB_EN & two_src & (src2==EXE_Dest); m_mem1 and m_mem2 are the same using MEM_Dest/MEM_WB_EN.
- fwd_en=1: hazard = EXE_MEM_R_EN & (m_exe1|m_exe2). This gives a one-cycle load-use stall; on the next cycle the load is in MEM and forwarding covers it.
- fwd_en=0: hazard = m_exe1|m_exe2|m_mem1|m_mem2.
- src2 is ignored when two_src=0. Register 15 (PC) has no special case.
- mem_req = MEM_R_EN|MEM_W_EN.
- FSM states IDLE, WAIT:
  - IDLE: if mem_req & !mem_ready -> WAIT, wait_cnt<=1, freeze=1 this cycle. If mem_req & mem_ready (zero-wait access), stay in IDLE with freeze=0.
  - WAIT: freeze = !mem_ready.
    - mem_ready=1 -> IDLE, wait_cnt<=0; freeze=0 in that same cycle, so the pipeline advances at that edge.
    - Else if wait_cnt==WAIT_MAX-1 -> IDLE, timeout<=1, freeze=0 that cycle (access abandoned).
    - Else wait_cnt<=wait_cnt+1.
- freeze dominates hazard: downstream logic treats hazard as don't-care while freeze=1. Both are still driven as specified.
- timeout clears only on rst. A subsequent request still runs the FSM normally.
- mem_req dropping while in WAIT, which is a protocol violation, is not checked; the FSM still waits for mem_ready or timeout.
- No combinational path from mem_ready to hazard.

Optional Feature:
- Macro HAZARD_STALL_PERF_EN.
- Defined: stall_cycles port exists. It increments by 1 every cycle that (hazard|freeze)=1 and saturates at all-ones (no wrap); it resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - REG_W=4.
  - Stall FSM state encoding ST_IDLE=1'b0, ST_WAIT=1'b1.
  - Default WAIT_MAX.
- One natural sub-module: hazard_match, the purely combinational dependency compare producing hazard.
- The FSM, watchdog and optional counter stay in the top module.

Test Plan:
- Load-use: fwd_en=1, EXE_MEM_R_EN=1, EXE_WB_EN=1, EXE_Dest=3, src1=3 -> hazard=1 for exactly that cycle. With src1=4, two_src=0, src2=3 -> hazard=0.
- No-forward MEM dependency: fwd_en=0, MEM_WB_EN=1, MEM_Dest=7, src2=7, two_src=1 -> hazard=1. Same inputs with fwd_en=1 -> hazard=0.
- Memory wait: MEM_R_EN=1, mem_ready low for 5 cycles then high -> freeze=1 for 5 cycles, 0 in the mem_ready cycle; state returns to IDLE; timeout=0.
- Zero-wait store: MEM_W_EN=1 and mem_ready=1 in the same cycle -> freeze never asserts; state stays IDLE.
- Watchdog: WAIT_MAX=4, MEM_R_EN=1, mem_ready held 0 -> freeze=1 for 3 cycles, 0 on the 4th; timeout=1 from the next edge and stays set until rst. Then rst=1 for one cycle -> timeout=0, state IDLE.
- Perf counter, with HAZARD_STALL_PERF_EN and CNT_W=2: 5 consecutive stall cycles -> stall_cycles reads 1,2,3,3,3. Assert rst mid-WAIT -> freeze=0 and stall_cycles=0 on the next cycle.
